// File: rtl/filtb_mc.sv
// Multi-channel pipelined long-term magnitude filter: DMLP = DML + ((FI<<FI_SHIFT) - DML) >>> LPF_SHIFT.
// Define FILTB_MC_FWD_EN to forward same-channel results instead of inserting a one-cycle bubble.
module filtb_mc #(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned CH_W      = 2,
    parameter int unsigned FI_W      = 3,
    parameter int unsigned DML_W     = 14,
    parameter int unsigned FI_SHIFT  = 11,
    parameter int unsigned LPF_SHIFT = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CH_W-1:0]  in_ch,
    input  logic [FI_W-1:0]  in_fi,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CH_W-1:0]  out_ch,
    output logic [DML_W-1:0] out_dml,
    input  logic             clr,
    input  logic [CH_W-1:0]  clr_ch
);

    localparam int unsigned D = DML_W + 1;

    logic [DML_W-1:0] state_q [NUM_CH];

    logic             s1_valid_q;
    logic [CH_W-1:0]  s1_ch_q;
    logic [FI_W-1:0]  s1_fi_q;
    logic [DML_W-1:0] s1_dml_q;

    logic             out_valid_q;
    logic [CH_W-1:0]  out_ch_q;
    logic [DML_W-1:0] out_dml_q;

    logic             s1_adv;
    logic             hazard;
    logic             accept;
    logic             in_ch_ok;
    logic [D-1:0]     fi_sh;
    logic [D-1:0]     dif;
    logic [D-1:0]     dif_sh;
    logic [DML_W-1:0] dmlp;
    logic [DML_W-1:0] rd_dml;

    // Filter arithmetic on the S1 contents; dif is a signed D-bit difference.
    always_comb begin
        fi_sh  = D'(s1_fi_q) << FI_SHIFT;
        dif    = fi_sh - {1'b0, s1_dml_q};
        dif_sh = $signed(dif) >>> LPF_SHIFT;
        dmlp   = DML_W'({1'b0, s1_dml_q} + dif_sh);
    end

    always_comb begin
        s1_adv   = s1_valid_q && (!out_valid_q || out_ready);
`ifdef FILTB_MC_FWD_EN
        hazard   = 1'b0;
`else
        // Without forwarding, a same-channel sample waits until S1 has written back.
        hazard   = s1_valid_q && (in_ch == s1_ch_q);
`endif
        in_ready = (!s1_valid_q || s1_adv) && !hazard;
        accept   = in_valid && in_ready;
        in_ch_ok = 32'(in_ch) < NUM_CH;
    end

    // State read for the incoming sample; a same-edge clear forces zero.
    always_comb begin
        rd_dml = '0;
        if (in_ch_ok) begin
            rd_dml = state_q[in_ch];
        end
`ifdef FILTB_MC_FWD_EN
        if (s1_adv && (32'(s1_ch_q) < NUM_CH) && (s1_ch_q == in_ch)) begin
            rd_dml = dmlp;
        end
`endif
        if (clr && (clr_ch == in_ch)) begin
            rd_dml = '0;
        end
    end

    // Out-of-range channels never match an index, so they neither write back nor clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_CH; k++) begin
                state_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (clr && (clr_ch == CH_W'(k))) begin
                    state_q[k] <= '0;
                end else if (s1_adv && (s1_ch_q == CH_W'(k))) begin
                    state_q[k] <= dmlp;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_ch_q     <= '0;
            s1_fi_q     <= '0;
            s1_dml_q    <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_dml_q   <= '0;
        end else begin
            if (accept) begin
                s1_valid_q <= 1'b1;
                s1_ch_q    <= in_ch;
                s1_fi_q    <= in_fi;
                s1_dml_q   <= rd_dml;
            end else if (s1_adv) begin
                s1_valid_q <= 1'b0;
            end
            if (s1_adv) begin
                out_valid_q <= 1'b1;
                out_ch_q    <= s1_ch_q;
                out_dml_q   <= dmlp;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign out_dml   = out_dml_q;

endmodule
